// File: rtl/muldiv_sequencer.sv
// Launches mult/div operations, counts unit latency, commits HI/LO and reports done/divide-by-zero.
// Optional divisor==0 refusal is enabled by defining MULDIV_ZERO_CHECK_EN.
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] divisor,
    output logic        multControl,
    output logic        divControl,
    output logic        muxHiControl,
    output logic        muxLoControl,
    output logic        HiWrite,
    output logic        LoWrite,
    output logic        busy,
    output logic        done,
    output logic        divz_exc
);

    // state   | meaning
    // IDLE    | waiting for a start request
    // LAUNCH  | one-cycle start pulse to the selected unit, counter loaded
    // RUN     | unit latency countdown
    // WRITE   | HI/LO load enables asserted
    // DONE    | completion pulse; new starts accepted as in IDLE
    // EXC     | divide-by-zero refused
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_WRITE, S_DONE, S_EXC
    } state_t;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

`ifdef MULDIV_ZERO_CHECK_EN
    localparam bit ZERO_CHECK = 1'b1;
`else
    localparam bit ZERO_CHECK = 1'b0;
`endif

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_div;

    assign zero_div = ZERO_CHECK && (divisor == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // mult has priority when both requests arrive together
                if (start_mult) begin
                    op_d    = 1'b0;
                    state_d = S_LAUNCH;
                end else if (start_div) begin
                    op_d    = 1'b1;
                    state_d = zero_div ? S_EXC : S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d   = op_q ? DIV_LOAD : MULT_LOAD;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == '0) state_d = S_WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WRITE: state_d = S_DONE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        multControl  = 1'b0;
        divControl   = 1'b0;
        HiWrite      = 1'b0;
        LoWrite      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        divz_exc     = 1'b0;
        muxHiControl = op_q;
        muxLoControl = op_q;
        case (state_q)
            S_LAUNCH: begin
                multControl = ~op_q;
                divControl  = op_q;
                busy        = 1'b1;
            end
            S_RUN: busy = 1'b1;
            S_WRITE: begin
                HiWrite = 1'b1;
                LoWrite = 1'b1;
                busy    = 1'b1;
            end
            S_DONE:  done     = 1'b1;
            S_EXC:   divz_exc = ZERO_CHECK;
            default: ;
        endcase
    end

endmodule
